// File: rtl/mem_ctrl_if.sv
// Request/response and byte-wide RAM bus bundle for mem_ctrl.
// slave is the controller's view; master is the core/RAM side driving it.
interface mem_ctrl_if;
  logic        LSB_enable;
  logic        LSB_is_write;
  logic [31:0] LSB_addr;
  logic [2:0]  LSB_data_len;
  logic [31:0] LSB_write_data;
  logic        LSB_data_valid;
  logic [31:0] LSB_data;

  logic        IF_enable;
  logic [31:0] IF_addr;
  logic        IF_data_valid;
  logic [31:0] IF_data;

  logic [7:0]  mem_din;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;

  modport slave (
    input  LSB_enable, LSB_is_write, LSB_addr, LSB_data_len, LSB_write_data,
    input  IF_enable, IF_addr, mem_din, io_buffer_full,
    output LSB_data_valid, LSB_data, IF_data_valid, IF_data,
    output mem_dout, mem_a, mem_wr
  );

  modport master (
    output LSB_enable, LSB_is_write, LSB_addr, LSB_data_len, LSB_write_data,
    output IF_enable, IF_addr, mem_din, io_buffer_full,
    input  LSB_data_valid, LSB_data, IF_data_valid, IF_data,
    input  mem_dout, mem_a, mem_wr
  );
endinterface

// File: rtl/mem_ctrl.sv
// Memory controller: arbitrates load/store and fetch requests and
// serialises each access into little-endian single-byte RAM cycles.
//
//   state | meaning
//   IDLE  | sample requests (LSB before IF), latch base/len/data
//   READ  | issue read addresses, gather bytes one cycle behind
//   WRITE | drive one byte per cycle, holding while IO buffer is full
//   DONE  | single cooldown cycle, requests ignored (stale upstream)
module mem_ctrl (
  input  logic       clk,
  input  logic       rst,
  input  logic       rdy,
  input  logic       clear,
  mem_ctrl_if.slave  bus
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] READ  = 2'd1;
  localparam logic [1:0] WRITE = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]  state;
  logic        owner_if;
  logic [31:0] base;
  logic [2:0]  len;
  logic [2:0]  cnt;
  logic [31:0] wdata;
  logic [31:0] rbuf;
  logic        suppress;
  logic [31:0] rd_word;
  logic [1:0]  lane;
  logic        io_stall;

  // Writes into the IO window wait while the IO buffer cannot take a byte.
  assign io_stall = (base[17:16] == 2'b11) && bus.io_buffer_full;

  // The byte on mem_din belongs to the address issued one cycle earlier.
  assign lane = cnt[1:0] - 2'd1;

  // Gathered read data with the byte currently on mem_din merged in.
  always_comb begin
    rd_word = rbuf;
    rd_word[{lane, 3'b000} +: 8] = bus.mem_din;
  end

  // RAM port drive; address is withheld in the final capture cycle of a
  // read and during IO stalls so no extra IO location is touched.
  always_comb begin
    bus.mem_a    = '0;
    bus.mem_dout = '0;
    bus.mem_wr   = 1'b0;
    case (state)
      READ: begin
        if (cnt != len) bus.mem_a = base + {29'd0, cnt};
      end
      WRITE: begin
        if (!io_stall) begin
          bus.mem_a    = base + {29'd0, cnt};
          bus.mem_dout = wdata[{cnt[1:0], 3'b000} +: 8];
          bus.mem_wr   = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Sequencing, byte counter and registered completion outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      owner_if           <= 1'b0;
      base               <= '0;
      len                <= '0;
      cnt                <= '0;
      wdata              <= '0;
      rbuf               <= '0;
      suppress           <= 1'b0;
      bus.LSB_data_valid <= 1'b0;
      bus.IF_data_valid  <= 1'b0;
      bus.LSB_data       <= '0;
      bus.IF_data        <= '0;
    end else if (rdy) begin
      bus.LSB_data_valid <= 1'b0;
      bus.IF_data_valid  <= 1'b0;
      case (state)
        IDLE: begin
          if (!clear) begin
            if (bus.LSB_enable) begin
              owner_if <= 1'b0;
              base     <= bus.LSB_addr;
              len      <= bus.LSB_data_len;
              wdata    <= bus.LSB_write_data;
              cnt      <= '0;
              rbuf     <= '0;
              suppress <= 1'b0;
              state    <= bus.LSB_is_write ? WRITE : READ;
            end else if (bus.IF_enable) begin
              owner_if <= 1'b1;
              base     <= bus.IF_addr;
              len      <= 3'd4;
              wdata    <= '0;
              cnt      <= '0;
              rbuf     <= '0;
              suppress <= 1'b0;
              state    <= READ;
            end
          end
        end
        READ: begin
          if (clear) begin
            state <= IDLE;
          end else begin
            if (cnt != 3'd0) rbuf <= rd_word;
            if (cnt == len) begin
              state <= DONE;
              if (owner_if) begin
                bus.IF_data       <= rd_word;
                bus.IF_data_valid <= 1'b1;
              end else begin
                bus.LSB_data       <= rd_word;
                bus.LSB_data_valid <= 1'b1;
              end
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
        end
        WRITE: begin
          // A flushed store still completes; only its pulse is dropped.
          if (clear) suppress <= 1'b1;
          if (!io_stall) begin
            if (cnt == len - 3'd1) begin
              state              <= DONE;
              bus.LSB_data_valid <= !(suppress || clear);
            end else begin
              cnt <= cnt + 3'd1;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl with a byte RAM model and an IO write log.
module tb_mem_ctrl;

  logic clk;
  logic rst;
  logic rdy;
  logic clear;
  int   checks;
  int   failures;

  mem_ctrl_if bus();

  mem_ctrl dut (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .clear (clear),
    .bus   (bus)
  );

  logic [7:0] ram [0:1023];
  int         io_cnt;
  logic [7:0] io_last;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM model: one-cycle read latency, stalled by rdy; IO window logged.
  always @(posedge clk) begin
    if (rdy) begin
      if (bus.mem_wr) begin
        if (bus.mem_a == 32'h0003_0000) begin
          io_cnt  <= io_cnt + 1;
          io_last <= bus.mem_dout;
        end else if (bus.mem_a[31:10] == 22'd0) begin
          ram[bus.mem_a[9:0]] <= bus.mem_dout;
        end
      end
      bus.mem_din <= (bus.mem_a[31:10] == 22'd0) ? ram[bus.mem_a[9:0]] : 8'h00;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("excl", {31'd0, bus.LSB_data_valid & bus.IF_data_valid}, 32'd0);
  endtask

  task automatic lsb_req(input logic we, input logic [31:0] a, input logic [2:0] n,
                         input logic [31:0] d);
    bus.LSB_enable     = 1'b1;
    bus.LSB_is_write   = we;
    bus.LSB_addr       = a;
    bus.LSB_data_len   = n;
    bus.LSB_write_data = d;
  endtask

  task automatic load(input string tag, input logic [31:0] a, input logic [2:0] n,
                      input logic [31:0] exp);
    lsb_req(1'b0, a, n, 32'd0);
    for (int k = 0; k < int'(n); k++) begin
      tick();
      if (k == 0) bus.LSB_enable = 1'b0;
      chk({tag, "_a"}, bus.mem_a, a + k);
      chk({tag, "_wr"}, {31'd0, bus.mem_wr}, 32'd0);
    end
    tick();
    chk({tag, "_early"}, {31'd0, bus.LSB_data_valid}, 32'd0);
    tick();
    chk({tag, "_v"}, {31'd0, bus.LSB_data_valid}, 32'd1);
    chk({tag, "_d"}, bus.LSB_data, exp);
    tick();
    chk({tag, "_vend"}, {31'd0, bus.LSB_data_valid}, 32'd0);
  endtask

  task automatic store(input string tag, input logic [31:0] a, input logic [2:0] n,
                       input logic [31:0] d);
    lsb_req(1'b1, a, n, d);
    for (int k = 0; k < int'(n); k++) begin
      tick();
      if (k == 0) bus.LSB_enable = 1'b0;
      chk({tag, "_a"}, bus.mem_a, a + k);
      chk({tag, "_wr"}, {31'd0, bus.mem_wr}, 32'd1);
      chk({tag, "_dout"}, {24'd0, bus.mem_dout}, {24'd0, d[8*k +: 8]});
    end
    tick();
    chk({tag, "_v"}, {31'd0, bus.LSB_data_valid}, 32'd1);
    chk({tag, "_wr_off"}, {31'd0, bus.mem_wr}, 32'd0);
    tick();
    chk({tag, "_vend"}, {31'd0, bus.LSB_data_valid}, 32'd0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    io_cnt   = 0;
    io_last  = 8'h00;
    for (int i = 0; i < 1024; i++) ram[i] = 8'h00;
    ram[10'h100] = 8'h11; ram[10'h101] = 8'h22; ram[10'h102] = 8'h33; ram[10'h103] = 8'h44;
    ram[10'h080] = 8'h93; ram[10'h081] = 8'h00; ram[10'h082] = 8'h10; ram[10'h083] = 8'h00;
    bus.mem_din        = 8'h00;
    bus.io_buffer_full = 1'b0;
    bus.LSB_enable     = 1'b0;
    bus.LSB_is_write   = 1'b0;
    bus.LSB_addr       = '0;
    bus.LSB_data_len   = '0;
    bus.LSB_write_data = '0;
    bus.IF_enable      = 1'b0;
    bus.IF_addr        = '0;
    rst   = 1'b1;
    rdy   = 1'b1;
    clear = 1'b0;

    tick();
    tick();
    chk("rst_a",   bus.mem_a, 32'd0);
    chk("rst_wr",  {31'd0, bus.mem_wr}, 32'd0);
    chk("rst_do",  {24'd0, bus.mem_dout}, 32'd0);
    chk("rst_lv",  {31'd0, bus.LSB_data_valid}, 32'd0);
    chk("rst_iv",  {31'd0, bus.IF_data_valid}, 32'd0);
    chk("rst_ld",  bus.LSB_data, 32'd0);
    chk("rst_id",  bus.IF_data, 32'd0);
    rst = 1'b0;

    load("lw",  32'h100, 3'd4, 32'h4433_2211);
    load("lb",  32'h101, 3'd1, 32'h0000_0022);
    load("lh",  32'h102, 3'd2, 32'h0000_4433);
    store("sw", 32'h200, 3'd4, 32'hDEAD_BEEF);
    load("sw_rb", 32'h200, 3'd4, 32'hDEAD_BEEF);

    // clear while idle blocks acceptance for that cycle only
    lsb_req(1'b0, 32'h102, 3'd1, 32'd0);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clri_a0", bus.mem_a, 32'd0);
    tick();
    bus.LSB_enable = 1'b0;
    chk("clri_a1", bus.mem_a, 32'h102);
    tick();
    tick();
    chk("clri_v", {31'd0, bus.LSB_data_valid}, 32'd1);
    chk("clri_d", bus.LSB_data, 32'h0000_0033);
    tick();

    // arbitration: LSB first, fetch held high and sampled after DONE
    lsb_req(1'b0, 32'h100, 3'd4, 32'd0);
    bus.IF_enable = 1'b1;
    bus.IF_addr   = 32'h80;
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 0) bus.LSB_enable = 1'b0;
      chk("arb_la", bus.mem_a, 32'h100 + k);
    end
    tick();
    tick();
    chk("arb_lv", {31'd0, bus.LSB_data_valid}, 32'd1);
    chk("arb_ld", bus.LSB_data, 32'h4433_2211);
    chk("arb_iv0", {31'd0, bus.IF_data_valid}, 32'd0);
    tick();
    chk("arb_iv1", {31'd0, bus.IF_data_valid}, 32'd0);
    tick();
    bus.IF_enable = 1'b0;
    chk("arb_ia", bus.mem_a, 32'h80);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("arb_ivw", {31'd0, bus.IF_data_valid}, 32'd0);
    end
    tick();
    chk("arb_iv", {31'd0, bus.IF_data_valid}, 32'd1);
    chk("arb_id", bus.IF_data, 32'h0010_0093);
    chk("arb_lhold", bus.LSB_data, 32'h4433_2211);
    tick();
    chk("arb_ivend", {31'd0, bus.IF_data_valid}, 32'd0);

    // clear during a fetch aborts it; controller is idle the next cycle
    bus.IF_enable = 1'b1;
    bus.IF_addr   = 32'h100;
    tick();
    bus.IF_enable = 1'b0;
    chk("clrf_a0", bus.mem_a, 32'h100);
    tick();
    chk("clrf_a1", bus.mem_a, 32'h101);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clrf_idle", bus.mem_a, 32'd0);
    chk("clrf_iv", {31'd0, bus.IF_data_valid}, 32'd0);
    load("clrf_lb", 32'h103, 3'd1, 32'h0000_0044);
    chk("clrf_ihold", bus.IF_data, 32'h0010_0093);

    // rdy low stretches the valid pulse
    lsb_req(1'b0, 32'h100, 3'd1, 32'd0);
    tick();
    bus.LSB_enable = 1'b0;
    chk("rdy_a", bus.mem_a, 32'h100);
    tick();
    tick();
    chk("rdy_v", {31'd0, bus.LSB_data_valid}, 32'd1);
    chk("rdy_d", bus.LSB_data, 32'h0000_0011);
    rdy = 1'b0;
    tick();
    chk("rdy_hold1", {31'd0, bus.LSB_data_valid}, 32'd1);
    tick();
    chk("rdy_hold2", {31'd0, bus.LSB_data_valid}, 32'd1);
    rdy = 1'b1;
    tick();
    chk("rdy_vend", {31'd0, bus.LSB_data_valid}, 32'd0);

    // IO stall: three full cycles hold the byte back
    lsb_req(1'b1, 32'h0003_0000, 3'd1, 32'h0000_0041);
    bus.io_buffer_full = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      if (k == 0) bus.LSB_enable = 1'b0;
      chk("io_wr0", {31'd0, bus.mem_wr}, 32'd0);
      chk("io_do0", {24'd0, bus.mem_dout}, 32'd0);
      chk("io_v0", {31'd0, bus.LSB_data_valid}, 32'd0);
    end
    tick();
    bus.io_buffer_full = 1'b0;
    #1;
    chk("io_wr", {31'd0, bus.mem_wr}, 32'd1);
    chk("io_a", bus.mem_a, 32'h0003_0000);
    chk("io_do", {24'd0, bus.mem_dout}, 32'h41);
    tick();
    chk("io_v", {31'd0, bus.LSB_data_valid}, 32'd1);
    chk("io_cnt", io_cnt, 32'd1);
    chk("io_byte", {24'd0, io_last}, 32'h41);
    tick();
    chk("io_vend", {31'd0, bus.LSB_data_valid}, 32'd0);

    // clear during a store: all bytes still written, pulse suppressed
    lsb_req(1'b1, 32'h210, 3'd4, 32'h1234_5678);
    tick();
    bus.LSB_enable = 1'b0;
    chk("clrs_d0", {24'd0, bus.mem_dout}, 32'h78);
    tick();
    chk("clrs_d1", {24'd0, bus.mem_dout}, 32'h56);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clrs_wr2", {31'd0, bus.mem_wr}, 32'd1);
    chk("clrs_d2", {24'd0, bus.mem_dout}, 32'h34);
    tick();
    chk("clrs_d3", {24'd0, bus.mem_dout}, 32'h12);
    tick();
    chk("clrs_nov", {31'd0, bus.LSB_data_valid}, 32'd0);
    chk("clrs_wr", {31'd0, bus.mem_wr}, 32'd0);
    tick();
    chk("clrs_nov2", {31'd0, bus.LSB_data_valid}, 32'd0);
    load("clrs_rb", 32'h210, 3'd4, 32'h1234_5678);

    // reset mid-store abandons the remaining bytes
    lsb_req(1'b1, 32'h220, 3'd4, 32'hCAFE_F00D);
    tick();
    bus.LSB_enable = 1'b0;
    chk("rsto_d0", {24'd0, bus.mem_dout}, 32'h0D);
    tick();
    chk("rsto_d1", {24'd0, bus.mem_dout}, 32'hF0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rsto_a",  bus.mem_a, 32'd0);
    chk("rsto_wr", {31'd0, bus.mem_wr}, 32'd0);
    chk("rsto_do", {24'd0, bus.mem_dout}, 32'd0);
    chk("rsto_lv", {31'd0, bus.LSB_data_valid}, 32'd0);
    chk("rsto_iv", {31'd0, bus.IF_data_valid}, 32'd0);
    chk("rsto_ld", bus.LSB_data, 32'd0);
    chk("rsto_id", bus.IF_data, 32'd0);
    load("rsto_rb", 32'h220, 3'd4, 32'h0000_F00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
